// File: rtl/prog_mem.sv
// Program memory for the 4-bit CPU: combinational fetch port plus a valid/ready byte loader
// that holds the CPU in reset while it fills the array. Define PROG_MEM_DEFAULT_PROG_EN to boot the LED demo.
module prog_mem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              cpu_hold,
   output logic              loaded,
   output logic [ADDR_W:0]   ld_count
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic {LOAD, RUN} state_t;

`ifdef PROG_MEM_DEFAULT_PROG_EN
   localparam state_t RST_STATE = RUN;
`else
   localparam state_t RST_STATE = LOAD;
`endif

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   ptr;
   logic              hs;

   // ld_start wins over a same-cycle word, so that word is dropped
   assign hs       = ld_valid && (state == LOAD) && !ld_start;
   assign ld_ready = (state == LOAD);
   assign cpu_hold = (state == LOAD);
   assign loaded   = (state == RUN);
   assign data     = (state == RUN) ? mem[addr] : '0;
   assign ld_count = ptr;

   always_ff @(posedge clk) begin
      if (rst) state <= RST_STATE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ld_start)
         state_nxt = LOAD;
      else if (hs && (ld_last || ptr == LAST_PTR))
         state_nxt = RUN;
   end

   always_ff @(posedge clk) begin
      if (rst || ld_start) ptr <= '0;
      else if (hs)         ptr <= ptr + (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
`ifdef PROG_MEM_DEFAULT_PROG_EN
            case (i)
               0:       mem[i] <= DATA_W'(8'hB1);
               1:       mem[i] <= DATA_W'(8'hB2);
               2:       mem[i] <= DATA_W'(8'hB4);
               3:       mem[i] <= DATA_W'(8'hB8);
               4:       mem[i] <= DATA_W'(8'hF0);
               default: mem[i] <= '0;
            endcase
`else
            mem[i] <= '0;
`endif
         end
      end else if (hs) begin
         mem[ptr[ADDR_W-1:0]] <= ld_data;
      end
   end
endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: vector table, hand sequences and random traffic against a behavioural model.
module tb_prog_mem;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] data;
   logic       ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0] ld_data = '0;
   logic       ld_ready, cpu_hold, loaded;
   logic [4:0] ld_count;

   int checks = 0;
   int failures = 0;

   // reference model
   logic [7:0] m_mem [16];
   bit         m_load;
   int         m_cnt;
   bit         m_known = 0;

   prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last), .cpu_hold(cpu_hold),
      .loaded(loaded), .ld_count(ld_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_known = 1;
      m_cnt   = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
`ifdef PROG_MEM_DEFAULT_PROG_EN
      m_load   = 0;
      m_mem[0] = 8'hB1; m_mem[1] = 8'hB2; m_mem[2] = 8'hB4;
      m_mem[3] = 8'hB8; m_mem[4] = 8'hF0;
`else
      m_load   = 1;
`endif
   endtask

   task automatic model_cmp();
      chk("m_data",   {24'h0, data},      m_load ? 32'h0 : {24'h0, m_mem[addr]});
      chk("m_ready",  {31'h0, ld_ready},  {31'h0, m_load});
      chk("m_hold",   {31'h0, cpu_hold},  {31'h0, m_load});
      chk("m_loaded", {31'h0, loaded},    {31'h0, !m_load});
      chk("m_count",  {27'h0, ld_count},  m_cnt);
   endtask

   // one clock: drive, compare pre-edge outputs, clock, advance model
   task automatic step(input logic r, input logic s, input logic v,
                       input logic [7:0] d, input logic l, input logic [3:0] a);
      rst = r; ld_start = s; ld_valid = v; ld_data = d; ld_last = l; addr = a;
      #3;
      if (m_known) model_cmp();
      @(posedge clk);
      if (r) model_reset();
      else if (s) begin
         m_load = 1; m_cnt = 0;
      end else if (m_load && v) begin
         m_mem[m_cnt] = d;
         m_cnt++;
         if (l || m_cnt == 16) m_load = 0;
      end
      #1;
      rst = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
   endtask

   typedef struct {
      logic       s, v, l;
      logic [7:0] d;
      logic [3:0] a;
      logic [7:0] e_data;
      logic       e_hold, e_loaded;
      logic [4:0] e_cnt;
   } vec_t;
   vec_t tbl [15];

   initial begin
      // s v l  d      a   data  hold ld  cnt
      tbl[0]  = '{0,0,0, 8'h00, 5, 8'h00, 1,0, 0};
      tbl[1]  = '{0,1,0, 8'hB5, 0, 8'h00, 1,0, 0};
      tbl[2]  = '{0,1,0, 8'hB3, 0, 8'h00, 1,0, 1};
      tbl[3]  = '{0,1,1, 8'hF0, 0, 8'h00, 1,0, 2};
      tbl[4]  = '{0,0,0, 8'h00, 0, 8'hB5, 0,1, 3};
      tbl[5]  = '{0,0,0, 8'h00, 1, 8'hB3, 0,1, 3};
      tbl[6]  = '{0,0,0, 8'h00, 2, 8'hF0, 0,1, 3};
      tbl[7]  = '{0,0,0, 8'h00, 3, 8'h00, 0,1, 3};
      tbl[8]  = '{0,1,1, 8'h77, 3, 8'h00, 0,1, 3};
      tbl[9]  = '{0,0,0, 8'h00, 3, 8'h00, 0,1, 3};
      tbl[10] = '{1,1,0, 8'hAA, 0, 8'hB5, 0,1, 3};
      tbl[11] = '{0,0,0, 8'h00, 0, 8'h00, 1,0, 0};
      tbl[12] = '{0,1,1, 8'hAA, 1, 8'h00, 1,0, 0};
      tbl[13] = '{0,0,0, 8'h00, 0, 8'hAA, 0,1, 1};
      tbl[14] = '{0,0,0, 8'h00, 1, 8'hB3, 0,1, 1};

      @(posedge clk); #1;
      step(1, 0, 0, 8'h00, 0, 0);

`ifndef PROG_MEM_DEFAULT_PROG_EN
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a); #1;
         chk("rst_idle_data", {24'h0, data}, 32'h0);
      end
      chk("rst_hold",  {31'h0, cpu_hold}, 32'h1);
      chk("rst_ready", {31'h0, ld_ready}, 32'h1);
      chk("rst_loaded",{31'h0, loaded},   32'h0);

      for (int i = 0; i < 15; i++) begin
         rst = 0; ld_start = tbl[i].s; ld_valid = tbl[i].v; ld_last = tbl[i].l;
         ld_data = tbl[i].d; addr = tbl[i].a;
         #2;
         chk("tbl_data",   {24'h0, data},     {24'h0, tbl[i].e_data});
         chk("tbl_hold",   {31'h0, cpu_hold}, {31'h0, tbl[i].e_hold});
         chk("tbl_loaded", {31'h0, loaded},   {31'h0, tbl[i].e_loaded});
         chk("tbl_count",  {27'h0, ld_count}, {27'h0, tbl[i].e_cnt});
         step(0, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a);
      end
`endif

      // full 16-word image without ld_last, with gaps between words
      step(0, 1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i % 5 == 2) step(0, 0, 0, 8'h99, 0, 0);
         step(0, 0, 1, 8'(8'h10 + i), 0, 0);
      end
      addr = 4'd15; #1;
      chk("full_loaded", {31'h0, loaded},   32'h1);
      chk("full_count",  {27'h0, ld_count}, 32'd16);
      chk("full_a15",    {24'h0, data},     32'h1F);
      step(0, 0, 1, 8'h55, 1, 4'd7);
      step(0, 0, 0, 8'h00, 0, 4'd7);
      chk("run_novalid_count", {27'h0, ld_count}, 32'd16);
      chk("run_novalid_a7",    {24'h0, data},     32'h17);

      // reset mid-load
      step(0, 1, 0, 8'h00, 0, 0);
      step(0, 0, 1, 8'hC1, 0, 0);
      step(0, 0, 1, 8'hC2, 0, 0);
      step(1, 0, 1, 8'hC3, 0, 0);
      addr = 4'd4; #1;
      chk("mid_rst_count", {27'h0, ld_count}, 32'h0);
`ifdef PROG_MEM_DEFAULT_PROG_EN
      chk("mid_rst_loaded", {31'h0, loaded},   32'h1);
      chk("mid_rst_hold",   {31'h0, cpu_hold}, 32'h0);
      chk("mid_rst_a4",     {24'h0, data},     32'hF0);
`else
      chk("mid_rst_loaded", {31'h0, loaded},   32'h0);
      chk("mid_rst_hold",   {31'h0, cpu_hold}, 32'h1);
      chk("mid_rst_data",   {24'h0, data},     32'h0);
      step(0, 0, 1, 8'h5A, 1, 0);
      addr = 4'd1; #1;
      chk("mid_rst_mem1", {24'h0, data}, 32'h0);
      addr = 4'd0; #1;
      chk("mid_rst_mem0", {24'h0, data}, 32'h5A);
`endif

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(63) == 0), ($urandom_range(19) == 0),
              $urandom_range(1) == 1, 8'($urandom), ($urandom_range(7) == 0),
              4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
